ldtu_sample_encoder: RTL and testbench
======================================

# ldtu_sample_encoder

Packs the 13-bit per-cycle sample stream produced by the input FIFO/gain-selection stage into 32-bit words for the serializer. It consumes `DATA_to_enc` and `baseline_flag`, one sample per CLK cycle with no stall capability. Baseline samples are compressed to 6 bits, five per word; signal samples keep all 13 bits, two per word. Words are buffered in a small output FIFO with a valid/ready handshake toward the serializer.

## Interface
Parameters:
- `OutFifoDepth`, 4: output word FIFO depth (power of 2).
- `NBitsLvl`, 3: width of fill-level counter, log2(OutFifoDepth)+1.

Ports:
- `CLK`  in  1  LiTe-DTU clock.
- `rst_b`  in  1  Reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- `DATA_to_enc`  in  13  Bit 12 = gain flag (1 = gain x1), [11:0] = sample; valid every cycle.
- `baseline_flag`  in  1  1 = baseline sample (only [5:0] meaningful).
- `word_ready`  in  1  Serializer accepts head word this cycle.
- `word_out`  out  32  Head word of output FIFO.
- `word_valid`  out  1  FIFO not empty.
- `fill_level`  out  NBitsLvl  Words currently stored.
- `fifo_overflow`  out  1  Sticky: a word was dropped.

## Operation
- Word formats:
  - Full baseline: [31:30]=2'b01; samples b0..b4 in [5:0],[11:6],…,[29:24], with b0 the oldest.
  - Partial baseline: [31:29]=3'b110; [28:26]=count n (1..4); b0..b(n-1) packed from [5:0]; unused bits 0.
  - Full signal: [31:26]=6'b001010; first sample [12:0], second [25:13].
  - Partial signal: [31:26]=6'b001011; sample [12:0]; [25:13]=0.
- FSM states: BASE (baseline count `bcnt` 0..4), SIG (`held` 0/1). At most one word is emitted per cycle. Transitions:
  - BASE, baseline in:
    - Store sample at `bcnt`.
    - If `bcnt`==4, emit full baseline and set `bcnt`=0; else `bcnt`+1.
  - BASE, signal in:
    - If `bcnt`>0, emit partial baseline (count=`bcnt`).
    - Hold the sample; go to SIG with `held`=1.
  - SIG `held`=1, signal in: emit full signal; `held`=0.
  - SIG `held`=0, signal in: hold the sample; `held`=1.
  - SIG, baseline in:
    - If `held`=1, emit partial signal.
    - Store the baseline sample as b0; go to BASE with `bcnt`=1.
- Output FIFO:
  - Show-ahead: `word_out` = head word whenever `word_valid`=1.
  - Pop on `word_valid && word_ready`.
  - Push when full without a simultaneous pop: word dropped, `fifo_overflow` set until reset.
  - Simultaneous push and pop when full: both performed; no overflow.
  - `word_ready` while empty: ignored.
  - Read/write pointers wrap modulo `OutFifoDepth`.
- `fifo_overflow` sets only on an actual drop.

## Timing
- Reset (`rst_b`=0 at a CLK edge):
  - State BASE, `bcnt`=0, `held`=0, FIFO emptied.
  - `word_out`=0, `word_valid`=0, `fill_level`=0, `fifo_overflow`=0.
  - Partially packed samples are discarded, including on reset mid-word.
- The sample at edge k that completes a word is pushed at edge k. With the FIFO empty, `word_valid`=1 and `word_out` = that word right after edge k (latency 1 edge).
- `fill_level` updates on the same edge as push/pop; net 0 when both occur.
- Sustained signal input: one word every 2 cycles. Sustained baseline: one word every 5 cycles. Alternating baseline/signal: one word per cycle worst case.
- With `word_ready` held high, the FIFO never overflows. Any `word_ready` deassertion longer than the FIFO can absorb drops words.

## Structure
- Package `ldtu_enc_pkg`:
  - Header constants: HDR_BASE=2'b01, HDR_BPART=3'b110, HDR_SIG=6'b001010, HDR_SPART=6'b001011.
  - State enum BASE/SIG.
  - Widths: 32-bit word, 6-bit baseline sample, 13-bit signal sample.
- Sub-module `ldtu_word_fifo`: parameterised synchronous show-ahead FIFO (CLK, rst_b, push/pop, full/empty, level). Top level holds the packer FSM and assembly registers.

## Test plan
- Reset, then baseline samples [5:0]=0x01..0x05 with `word_ready`=1: one word 0x45103081, `word_valid` high exactly one cycle after the 5th edge.
- Signal samples 0x1ABC then 0x0123 (baseline_flag=0): word 0x28247ABC.
- Baseline 0x3F, 0x01, then a signal: partial word 0xC800007F on the signal's edge. Then a baseline arrives after one signal 0x0FFF: partial signal word 0x2C000FFF.
- Alternate baseline/signal for 20 cycles with `word_ready`=1: one word per cycle after the first, `fill_level` ≤1, no overflow.
- `word_ready`=0 with continuous signal input:
  - `fill_level` reaches 4 after 8 samples; the 5th word is dropped and `fifo_overflow`=1.
  - Push+pop when full: no further drops.
- Assert `rst_b`=0 mid-word (`bcnt`=3): next edge all outputs 0; following baseline stream restarts at b0.

Source files
------------

// File: rtl/ldtu_sample_encoder_pkg.sv
// Shared types and constants for the LiTe-DTU sample encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: word/sample widths, word header codes, packer state enum and
// a helper that assembles a partial-baseline word from a sample count.
package ldtu_enc_pkg;

   localparam int WORD_W  = 32;
   localparam int BSAMP_W = 6;
   localparam int SSAMP_W = 13;
   localparam int BCNT_W  = 3;
   localparam int NBASE   = 5;

   localparam logic [1:0] HDR_BASE  = 2'b01;
   localparam logic [2:0] HDR_BPART = 3'b110;
   localparam logic [5:0] HDR_SIG   = 6'b001010;
   localparam logic [5:0] HDR_SPART = 6'b001011;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [BSAMP_W-1:0] bsamp_t;
   typedef logic [SSAMP_W-1:0] ssamp_t;

   typedef enum logic {
      BASE = 1'b0,
      SIG  = 1'b1
   } enc_state_t;

   // Partial baseline word: only the first n stored samples are placed,
   // stale assembly-register contents above n stay zero.
   function automatic word_t pack_bpart(input logic [3:0][BSAMP_W-1:0] b,
                                        input logic [BCNT_W-1:0] n);
      word_t w;
      w = '0;
      w[31:29] = HDR_BPART;
      w[28:26] = n;
      for (int i = 0; i < 4; i++) begin
         if (BCNT_W'(i) < n) begin
            w[i*BSAMP_W +: BSAMP_W] = b[i];
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/ldtu_sample_encoder_if.sv
// Word stream from the encoder towards the serializer.
// Latency: n/a (wires only).
// Backpressure: serializer drives word_ready; a word moves on word_valid && word_ready.
//
// Signals: word_out (head word), word_valid (FIFO not empty), word_ready (sink accepts).
interface ldtu_word_if;
   import ldtu_enc_pkg::*;

   word_t word_out;
   logic  word_valid;
   logic  word_ready;

   modport master (output word_out, output word_valid, input  word_ready);
   modport slave  (input  word_out, input  word_valid, output word_ready);

endinterface

// File: rtl/ldtu_sample_encoder_word_fifo.sv
// Synchronous show-ahead word FIFO with level counter and sticky overflow flag.
// Latency: a pushed word is visible at the head one edge after push when empty.
// Backpressure: push while full without a pop drops the word and sets o_overflow.
//
// Ports: CLK, rst_b (sync, active-low), i_push/i_push_dat, i_pop,
//        o_head_dat (zero when empty), o_empty, o_level, o_overflow.
module ldtu_word_fifo #(
   parameter int Depth = 4,
   parameter int LvlW  = 3,
   parameter int DatW  = 32
) (
   input  logic            CLK,
   input  logic            rst_b,
   input  logic            i_push,
   input  logic [DatW-1:0] i_push_dat,
   input  logic            i_pop,
   output logic [DatW-1:0] o_head_dat,
   output logic            o_empty,
   output logic [LvlW-1:0] o_level,
   output logic            o_overflow
);

   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [DatW-1:0] r_mem [Depth];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [LvlW-1:0] r_level;
   logic            r_overflow;

   logic w_full;
   logic w_empty;
   logic w_do_pop;
   logic w_do_push;

   assign w_full   = (r_level == LvlW'(Depth));
   assign w_empty  = (r_level == '0);
   // Pop on an empty FIFO is ignored; a pop frees the slot a full push needs.
   assign w_do_pop  = i_pop && !w_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);

   always_ff @(posedge CLK) begin
      if (!rst_b) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_level <= r_level + LvlW'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_level <= r_level - LvlW'(1);
         end
         if (i_push && !w_do_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge CLK) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_empty    = w_empty;
   assign o_level    = r_level;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/ldtu_sample_encoder.sv
// Packs one 13-bit sample per cycle into 32-bit words (5 baseline or 2 signal per word).
// Latency: the completing sample's edge pushes the word; visible at the head 1 edge later.
// Backpressure: none on the sample input; full output FIFO drops words and sets fifo_overflow.
//
// Ports: CLK, rst_b (sync, active-low), DATA_to_enc[12:0], baseline_flag,
//        word_if (master: word_out, word_valid, word_ready), fill_level, fifo_overflow.
module ldtu_sample_encoder
   import ldtu_enc_pkg::*;
#(
   parameter int OutFifoDepth = 4,
   parameter int NBitsLvl     = 3
) (
   input  logic                CLK,
   input  logic                rst_b,
   input  logic [12:0]         DATA_to_enc,
   input  logic                baseline_flag,
   ldtu_word_if.master         word_if,
   output logic [NBitsLvl-1:0] fill_level,
   output logic                fifo_overflow
);

   enc_state_t                r_state;
   logic [BCNT_W-1:0]         r_bcnt;
   logic [3:0][BSAMP_W-1:0]   r_bsamp;
   ssamp_t                    r_sig;
   logic                      r_held;

   logic  w_push;
   word_t w_word;
   logic  w_empty;

   // Word emission is decided from current state and the incoming sample so
   // the completing sample is pushed on its own edge.
   always_comb begin
      w_push = 1'b0;
      w_word = '0;
      unique case (r_state)
         BASE: begin
            if (baseline_flag) begin
               if (r_bcnt == BCNT_W'(NBASE - 1)) begin
                  w_push = 1'b1;
                  w_word = {HDR_BASE, DATA_to_enc[BSAMP_W-1:0],
                            r_bsamp[3], r_bsamp[2], r_bsamp[1], r_bsamp[0]};
               end
            end else if (r_bcnt != '0) begin
               w_push = 1'b1;
               w_word = pack_bpart(r_bsamp, r_bcnt);
            end
         end
         SIG: begin
            if (!baseline_flag) begin
               if (r_held) begin
                  w_push = 1'b1;
                  w_word = {HDR_SIG, DATA_to_enc, r_sig};
               end
            end else if (r_held) begin
               w_push = 1'b1;
               w_word = {HDR_SPART, {SSAMP_W{1'b0}}, r_sig};
            end
         end
         default: begin
            w_push = 1'b0;
            w_word = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!rst_b) begin
         r_state <= BASE;
         r_bcnt  <= '0;
         r_bsamp <= '0;
         r_sig   <= '0;
         r_held  <= 1'b0;
      end else begin
         unique case (r_state)
            BASE: begin
               if (baseline_flag) begin
                  if (r_bcnt == BCNT_W'(NBASE - 1)) begin
                     r_bcnt <= '0;
                  end else begin
                     r_bsamp[r_bcnt[1:0]] <= DATA_to_enc[BSAMP_W-1:0];
                     r_bcnt               <= r_bcnt + BCNT_W'(1);
                  end
               end else begin
                  r_sig   <= DATA_to_enc;
                  r_held  <= 1'b1;
                  r_bcnt  <= '0;
                  r_state <= SIG;
               end
            end
            SIG: begin
               if (!baseline_flag) begin
                  if (r_held) begin
                     r_held <= 1'b0;
                  end else begin
                     r_sig  <= DATA_to_enc;
                     r_held <= 1'b1;
                  end
               end else begin
                  r_bsamp[0] <= DATA_to_enc[BSAMP_W-1:0];
                  r_bcnt     <= BCNT_W'(1);
                  r_held     <= 1'b0;
                  r_state    <= BASE;
               end
            end
            default: begin
               r_state <= BASE;
            end
         endcase
      end
   end

   ldtu_word_fifo #(
      .Depth (OutFifoDepth),
      .LvlW  (NBitsLvl),
      .DatW  (WORD_W)
   ) u_word_fifo (
      .CLK        (CLK),
      .rst_b      (rst_b),
      .i_push     (w_push),
      .i_push_dat (w_word),
      .i_pop      (word_if.word_ready),
      .o_head_dat (word_if.word_out),
      .o_empty    (w_empty),
      .o_level    (fill_level),
      .o_overflow (fifo_overflow)
   );

   assign word_if.word_valid = !w_empty;

endmodule

// File: tb/tb_ldtu_sample_encoder.sv
// Scoreboard bench for ldtu_sample_encoder: directed sample streams push
// expected words into a queue; a monitor compares every accepted word.
module tb_ldtu_sample_encoder;

   logic        CLK;
   logic        rst_b;
   logic [12:0] DATA_to_enc;
   logic        baseline_flag;
   logic [2:0]  fill_level;
   logic        fifo_overflow;

   ldtu_word_if u_if ();

   ldtu_sample_encoder #(
      .OutFifoDepth (4),
      .NBitsLvl     (3)
   ) dut (
      .CLK           (CLK),
      .rst_b         (rst_b),
      .DATA_to_enc   (DATA_to_enc),
      .baseline_flag (baseline_flag),
      .word_if       (u_if),
      .fill_level    (fill_level),
      .fifo_overflow (fifo_overflow)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every accepted word must match the oldest expected word.
   always @(negedge CLK) begin
      if (rst_b && u_if.word_valid && u_if.word_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", u_if.word_out, 32'hxxxx_xxxx);
         end else begin
            check("word", u_if.word_out, exp_q.pop_front());
         end
      end
   end

   // One sample, one edge; returns 1 time unit after the edge.
   task automatic send(input logic bl, input logic [12:0] d,
                       input logic exp_push, input logic [31:0] exp_word);
      baseline_flag = bl;
      DATA_to_enc   = d;
      if (exp_push) exp_q.push_back(exp_word);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      check("drained_before_reset", 32'(exp_q.size()), 32'd0);
      rst_b = 1'b0;
      @(posedge CLK);
      #1;
      check("rst_word_out", u_if.word_out, 32'h0);
      check("rst_word_valid", 32'(u_if.word_valid), 32'd0);
      check("rst_fill_level", 32'(fill_level), 32'd0);
      check("rst_overflow", 32'(fifo_overflow), 32'd0);
      exp_q.delete();
      rst_b = 1'b1;
   endtask

   function automatic logic [31:0] sig_word(input logic [12:0] a, input logic [12:0] b);
      return 32'h2800_0000 | (32'(b) << 13) | 32'(a);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0] d;
      rst_b          = 1'b0;
      DATA_to_enc    = '0;
      baseline_flag  = 1'b1;
      u_if.word_ready = 1'b1;
      @(posedge CLK);
      #1;
      do_reset();

      // Five baselines -> one full baseline word, valid for exactly one cycle.
      for (int i = 1; i <= 4; i++) begin
         send(1'b1, 13'(i), 1'b0, 32'h0);
         check("base_no_word_yet", 32'(u_if.word_valid), 32'd0);
      end
      send(1'b1, 13'h05, 1'b1, 32'h4510_3081);
      check("base_valid_lat1", 32'(u_if.word_valid), 32'd1);
      check("base_head", u_if.word_out, 32'h4510_3081);

      // Signal pair -> full signal word.
      send(1'b0, 13'h1ABC, 1'b0, 32'h0);
      check("base_valid_one_cycle", 32'(u_if.word_valid), 32'd0);
      send(1'b0, 13'h0123, 1'b1, 32'h2824_7ABC);
      check("sig_head", u_if.word_out, 32'h2824_7ABC);

      // Partial baseline then partial signal.
      send(1'b1, 13'h003F, 1'b0, 32'h0);
      send(1'b1, 13'h0001, 1'b0, 32'h0);
      send(1'b0, 13'h0FFF, 1'b1, 32'hC800_007F);
      check("bpart_head", u_if.word_out, 32'hC800_007F);
      send(1'b1, 13'h0000, 1'b1, 32'h2C00_0FFF);
      check("spart_head", u_if.word_out, 32'h2C00_0FFF);
      send(1'b1, 13'h0000, 1'b0, 32'h0);
      do_reset();

      // Alternating baseline/signal: a word every cycle after the first.
      for (int i = 0; i < 22; i++) begin
         if (i % 2 == 0 || i == 21) begin
            d = 13'(i) & 13'h003F;
            if (i >= 2 && i <= 20)
               send(1'b1, d, 1'b1, 32'h2C00_0000 | 32'(13'h1000 | 13'(i - 1)));
            else
               send(1'b1, d, 1'b0, 32'h0);
         end else begin
            send(1'b0, 13'h1000 | 13'(i), 1'b1, 32'hC400_0000 | 32'(i - 1));
         end
         if (i >= 1 && i <= 20) begin
            check("alt_valid", 32'(u_if.word_valid), 32'd1);
            check("alt_level_le1", 32'(fill_level <= 3'd1), 32'd1);
         end
      end
      check("alt_no_overflow", 32'(fifo_overflow), 32'd0);
      do_reset();

      // Stalled sink with continuous signal input.
      u_if.word_ready = 1'b0;
      for (int j = 0; j < 10; j++) begin
         if (j % 2 == 1 && j < 8)
            send(1'b0, 13'h0100 + 13'(j), 1'b1, sig_word(13'h0100 + 13'(j - 1), 13'h0100 + 13'(j)));
         else
            send(1'b0, 13'h0100 + 13'(j), 1'b0, 32'h0);
         if (j == 7) begin
            check("stall_level_full", 32'(fill_level), 32'd4);
            check("stall_no_ovf_yet", 32'(fifo_overflow), 32'd0);
         end
      end
      check("stall_overflow", 32'(fifo_overflow), 32'd1);
      check("stall_level_hold", 32'(fill_level), 32'd4);
      send(1'b0, 13'h010A, 1'b0, 32'h0);
      u_if.word_ready = 1'b1;
      send(1'b0, 13'h010B, 1'b1, sig_word(13'h010A, 13'h010B));
      check("pushpop_full_level", 32'(fill_level), 32'd4);
      for (int k = 0; k < 4; k++) send(1'b1, 13'h0000, 1'b0, 32'h0);
      check("drain_level", 32'(fill_level), 32'd0);
      do_reset();

      // Reset mid-word discards the partial baseline.
      send(1'b1, 13'h0011, 1'b0, 32'h0);
      send(1'b1, 13'h0012, 1'b0, 32'h0);
      send(1'b1, 13'h0013, 1'b0, 32'h0);
      do_reset();
      for (int i = 0; i < 4; i++) send(1'b1, 13'h0021 + 13'(i), 1'b0, 32'h0);
      send(1'b1, 13'h0025, 1'b1, 32'h6592_38A1);
      check("restart_head", u_if.word_out, 32'h6592_38A1);
      send(1'b1, 13'h0000, 1'b0, 32'h0);
      check("final_drained", 32'(exp_q.size()), 32'd0);
      check("final_valid", 32'(u_if.word_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
